pipeline_stall_ctrl: RTL and testbench

//   Sequences pipeline stalls and flushes for the 5-stage core. It sits between the hazard detector,
//   the branch/flag logic and the data-memory port, and drives the IF/ID/EX hold and flush controls.

---
 rtl/pipeline_stall_ctrl.sv | 152 +++++++++++++++
 tb/tb_pipeline_stall_ctrl.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/pipeline_stall_ctrl.sv
// Stall/flush sequencer for the 5-stage core: load-use bubbles, branch-on-flag waits,
// taken-branch wrong-path kill, data-memory freeze, and saturating stall/flush statistics.
module pipeline_stall_ctrl #(
   parameter int unsigned CNT_W        = 16,
   parameter int unsigned MAX_BR_STALL = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             hz_load_use,
   input  logic             br_in_id,
   input  logic             br_flag_pend,
   input  logic             br_lw_flag_pend,
   input  logic             br_taken,
   input  logic             dmem_req,
   input  logic             dmem_ack,
   input  logic             cnt_clr,
   output logic             pc_write,
   output logic             if_write,
   output logic             idex_flush,
   output logic             ifid_flush,
   output logic             exmem_hold,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt,
   output logic             br_tmo_err
);

   typedef enum logic [1:0] {StRun, StBrWait, StMemWait} state_e;

   state_e           state_q, state_d;
   logic [7:0]       wait_q, wait_d;
   logic [8:0]       wait_inc;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
   logic             br_tmo_err_q, br_tmo_err_d;
   logic             tmo_set;
   logic             flag_pend, mem_stall;

   // Ungated controls; reset forcing is applied on the way out.
   logic pc_w, if_w, idex_f, ifid_f, hold;

   assign flag_pend = br_flag_pend | br_lw_flag_pend;
   assign mem_stall = dmem_req & ~dmem_ack;
   assign wait_inc  = {1'b0, wait_q} + 9'd1;

   // Next-state and control decode; priority order inside each state matters.
   always_comb begin
      state_d = state_q;
      wait_d  = wait_q;
      tmo_set = 1'b0;
      pc_w    = 1'b1;
      if_w    = 1'b1;
      idex_f  = 1'b0;
      ifid_f  = 1'b0;
      hold    = 1'b0;
      unique case (state_q)
         StRun: begin
            if (mem_stall) begin
               pc_w    = 1'b0;
               if_w    = 1'b0;
               hold    = 1'b1;
               state_d = StMemWait;
            end else if (hz_load_use) begin
               pc_w   = 1'b0;
               if_w   = 1'b0;
               idex_f = 1'b1;
            end else if (br_in_id && flag_pend) begin
               pc_w    = 1'b0;
               if_w    = 1'b0;
               idex_f  = 1'b1;
               wait_d  = 8'd1;
               state_d = StBrWait;
            end else if (br_in_id && br_taken) begin
               ifid_f = 1'b1;
            end
         end
         StBrWait: begin
            if (mem_stall) begin
               // Branch is dropped here and re-evaluated once back in RUN.
               pc_w    = 1'b0;
               if_w    = 1'b0;
               hold    = 1'b1;
               state_d = StMemWait;
            end else if (flag_pend) begin
               if (wait_inc >= 9'(MAX_BR_STALL)) begin
                  tmo_set = 1'b1;
                  state_d = StRun;
               end else begin
                  pc_w   = 1'b0;
                  if_w   = 1'b0;
                  idex_f = 1'b1;
                  wait_d = wait_inc[7:0];
               end
            end else begin
               ifid_f  = br_taken;
               state_d = StRun;
            end
         end
         StMemWait: begin
            if (!dmem_ack) begin
               pc_w = 1'b0;
               if_w = 1'b0;
               hold = 1'b1;
            end else begin
               state_d = StRun;
            end
         end
         default: state_d = StRun;
      endcase
   end

   // Saturating statistics and sticky watchdog error.
   always_comb begin
      stall_cnt_d  = stall_cnt_q;
      flush_cnt_d  = flush_cnt_q;
      br_tmo_err_d = br_tmo_err_q | tmo_set;
      if (cnt_clr) begin
         stall_cnt_d = '0;
         flush_cnt_d = '0;
      end else begin
         if (!pc_w && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
         if (ifid_f && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + 1'b1;
      end
   end

   // State and counter registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= StRun;
         wait_q       <= '0;
         stall_cnt_q  <= '0;
         flush_cnt_q  <= '0;
         br_tmo_err_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         wait_q       <= wait_d;
         stall_cnt_q  <= stall_cnt_d;
         flush_cnt_q  <= flush_cnt_d;
         br_tmo_err_q <= br_tmo_err_d;
      end
   end

   // While in reset: hold PC/IF and flush both front-end registers.
   assign pc_write   = rst_n & pc_w;
   assign if_write   = rst_n & if_w;
   assign idex_flush = ~rst_n | idex_f;
   assign ifid_flush = ~rst_n | ifid_f;
   assign exmem_hold = rst_n & hold;
   assign stall_cnt  = stall_cnt_q;
   assign flush_cnt  = flush_cnt_q;
   assign br_tmo_err = br_tmo_err_q;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed bench for pipeline_stall_ctrl. Inputs change on the falling edge; controls are
// sampled 1 ns later, counters after the following rising edge.
module tb_pipeline_stall_ctrl;

   logic clk = 1'b0;
   logic rst_n;
   logic hz_load_use, br_in_id, br_flag_pend, br_lw_flag_pend, br_taken;
   logic dmem_req, dmem_ack, cnt_clr;
   logic pc_write, if_write, idex_flush, ifid_flush, exmem_hold, br_tmo_err;
   logic [3:0] stall_cnt, flush_cnt;
   logic pc_write_w, if_write_w, idex_flush_w, ifid_flush_w, exmem_hold_w, br_tmo_err_w;
   logic [15:0] stall_cnt_w, flush_cnt_w;
   logic [4:0] ctl;

   int n_checks = 0;
   int n_errors = 0;

   // Control vector: {pc_write, if_write, idex_flush, ifid_flush, exmem_hold}
   localparam logic [4:0] CtlDef  = 5'b11000;
   localparam logic [4:0] CtlBub  = 5'b00100;
   localparam logic [4:0] CtlKill = 5'b11010;
   localparam logic [4:0] CtlHold = 5'b00001;
   localparam logic [4:0] CtlRst  = 5'b00110;

   assign ctl = {pc_write, if_write, idex_flush, ifid_flush, exmem_hold};

   always #5 clk = ~clk;

   pipeline_stall_ctrl #(.CNT_W(4), .MAX_BR_STALL(4)) dut (
      .clk(clk), .rst_n(rst_n), .hz_load_use(hz_load_use), .br_in_id(br_in_id),
      .br_flag_pend(br_flag_pend), .br_lw_flag_pend(br_lw_flag_pend), .br_taken(br_taken),
      .dmem_req(dmem_req), .dmem_ack(dmem_ack), .cnt_clr(cnt_clr),
      .pc_write(pc_write), .if_write(if_write), .idex_flush(idex_flush),
      .ifid_flush(ifid_flush), .exmem_hold(exmem_hold), .stall_cnt(stall_cnt),
      .flush_cnt(flush_cnt), .br_tmo_err(br_tmo_err)
   );

   // Default-width instance on the same stimulus, used for the non-saturating count.
   pipeline_stall_ctrl dut_w (
      .clk(clk), .rst_n(rst_n), .hz_load_use(hz_load_use), .br_in_id(br_in_id),
      .br_flag_pend(br_flag_pend), .br_lw_flag_pend(br_lw_flag_pend), .br_taken(br_taken),
      .dmem_req(dmem_req), .dmem_ack(dmem_ack), .cnt_clr(cnt_clr),
      .pc_write(pc_write_w), .if_write(if_write_w), .idex_flush(idex_flush_w),
      .ifid_flush(ifid_flush_w), .exmem_hold(exmem_hold_w), .stall_cnt(stall_cnt_w),
      .flush_cnt(flush_cnt_w), .br_tmo_err(br_tmo_err_w)
   );

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] want);
      n_checks++;
      if (act !== want) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, want);
      end
   endtask

   // Apply one cycle of inputs at the falling edge, then settle.
   task automatic drive(input logic hz, input logic br, input logic fp, input logic lwp,
                        input logic tk, input logic rq, input logic ak, input logic clr);
      @(negedge clk);
      hz_load_use = hz; br_in_id = br; br_flag_pend = fp; br_lw_flag_pend = lwp;
      br_taken = tk; dmem_req = rq; dmem_ack = ak; cnt_clr = clr;
      #1;
   endtask

   task automatic idle();
      drive(0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic clear_cnt();
      drive(0, 0, 0, 0, 0, 0, 0, 1);
   endtask

   initial begin
      rst_n = 1'b0;
      hz_load_use = 0; br_in_id = 0; br_flag_pend = 0; br_lw_flag_pend = 0;
      br_taken = 0; dmem_req = 0; dmem_ack = 0; cnt_clr = 0;
      #2;
      chk("reset_ctl", 32'(ctl), 32'(CtlRst));
      chk("reset_stall_cnt", 32'(stall_cnt), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("post_reset_ctl", 32'(ctl), 32'(CtlDef));

      // Load-use bubble for exactly one cycle.
      drive(1, 0, 0, 0, 0, 0, 0, 0);
      chk("lu_bubble", 32'(ctl), 32'(CtlBub));
      idle();
      chk("lu_after", 32'(ctl), 32'(CtlDef));
      chk("lu_stall_cnt", 32'(stall_cnt), 32'd1);

      // Branch waits one cycle on EX flag, then resolves taken.
      clear_cnt();
      drive(0, 1, 1, 0, 0, 0, 0, 0);
      chk("br1_stall", 32'(ctl), 32'(CtlBub));
      drive(0, 1, 0, 0, 1, 0, 0, 0);
      chk("br1_resolve_taken", 32'(ctl), 32'(CtlKill));
      idle();
      chk("br1_after", 32'(ctl), 32'(CtlDef));
      chk("br1_flush_cnt", 32'(flush_cnt), 32'd1);
      chk("br1_stall_cnt", 32'(stall_cnt), 32'd1);

      // Branch waits two cycles on a load flag, resolves not-taken.
      clear_cnt();
      drive(0, 1, 0, 1, 0, 0, 0, 0);
      chk("br2_stall_a", 32'(ctl), 32'(CtlBub));
      drive(0, 1, 0, 1, 0, 0, 0, 0);
      chk("br2_stall_b", 32'(ctl), 32'(CtlBub));
      drive(0, 1, 0, 0, 0, 0, 0, 0);
      chk("br2_resolve_nt", 32'(ctl), 32'(CtlDef));
      idle();
      chk("br2_stall_cnt", 32'(stall_cnt), 32'd2);
      chk("br2_flush_cnt", 32'(flush_cnt), 32'd0);

      // Memory freeze beats load-use; hazard seen only once back in RUN.
      clear_cnt();
      for (int i = 0; i < 3; i++) begin
         drive(1, 0, 0, 0, 0, 1, 0, 0);
         chk($sformatf("mem_hold_%0d", i), 32'(ctl), 32'(CtlHold));
      end
      drive(1, 0, 0, 0, 0, 1, 1, 0);
      chk("mem_ack", 32'(ctl), 32'(CtlDef));
      drive(1, 0, 0, 0, 0, 0, 0, 0);
      chk("mem_then_lu", 32'(ctl), 32'(CtlBub));
      idle();
      chk("mem_stall_cnt", 32'(stall_cnt), 32'd4);

      // Same-cycle ack is no stall; taken branch with flags ready kills IF/ID.
      drive(0, 0, 0, 0, 0, 1, 1, 0);
      chk("mem_same_cycle", 32'(ctl), 32'(CtlDef));
      drive(0, 1, 0, 0, 1, 0, 0, 0);
      chk("br_taken_run", 32'(ctl), 32'(CtlKill));

      // Memory stall in BR_WAIT wins; pending branch ignored while frozen.
      drive(0, 1, 1, 0, 0, 0, 0, 0);
      chk("brm_stall", 32'(ctl), 32'(CtlBub));
      drive(0, 1, 1, 0, 0, 1, 0, 0);
      chk("brm_mem_wins", 32'(ctl), 32'(CtlHold));
      drive(0, 1, 1, 0, 0, 1, 1, 0);
      chk("brm_ack_ignores_br", 32'(ctl), 32'(CtlDef));
      drive(0, 1, 0, 0, 1, 0, 0, 0);
      chk("brm_reeval_run", 32'(ctl), 32'(CtlKill));

      // Watchdog: pending for 4 cycles fires on the 4th.
      clear_cnt();
      for (int i = 0; i < 3; i++) begin
         drive(0, 1, 1, 0, 0, 0, 0, 0);
         chk($sformatf("wd_stall_%0d", i), 32'(ctl), 32'(CtlBub));
      end
      chk("wd_err_before", 32'(br_tmo_err), 32'd0);
      drive(0, 1, 1, 0, 0, 0, 0, 0);
      chk("wd_fire_defaults", 32'(ctl), 32'(CtlDef));
      idle();
      chk("wd_err_set", 32'(br_tmo_err), 32'd1);
      chk("wd_stall_cnt", 32'(stall_cnt), 32'd3);
      drive(1, 0, 0, 0, 0, 0, 0, 0);
      chk("wd_back_in_run", 32'(ctl), 32'(CtlBub));
      idle();
      idle();
      chk("wd_err_sticky", 32'(br_tmo_err), 32'd1);

      // Saturation at 4 bits vs. plain count at 16 bits; clear beats increment.
      clear_cnt();
      for (int i = 0; i < 20; i++) drive(1, 0, 0, 0, 0, 0, 0, 0);
      idle();
      chk("sat_stall_cnt", 32'(stall_cnt), 32'd15);
      chk("wide_stall_cnt", 32'(stall_cnt_w), 32'd20);
      drive(1, 0, 0, 0, 0, 0, 0, 1);
      idle();
      chk("clr_wins", 32'(stall_cnt), 32'd0);

      // Asynchronous reset in the middle of a memory wait.
      drive(0, 0, 0, 0, 0, 1, 0, 0);
      drive(0, 0, 0, 0, 0, 1, 0, 0);
      chk("pre_rst_hold", 32'(ctl), 32'(CtlHold));
      #2 rst_n = 1'b0;
      #1;
      chk("rst_mid_ctl", 32'(ctl), 32'(CtlRst));
      chk("rst_mid_stall_cnt", 32'(stall_cnt), 32'd0);
      chk("rst_mid_err", 32'(br_tmo_err), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      hz_load_use = 1'b1; dmem_req = 1'b0;
      #1;
      chk("rst_first_run", 32'(ctl), 32'(CtlBub));
      idle();
      chk("rst_stall_cnt", 32'(stall_cnt), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
